// File: rtl/phold_engine.sv
// PHOLD benchmark engine: seeds one event per LP, then pops min-time events and schedules random successors.
// Optional PHOLD_TRACE_EN prints every generated event during simulation.
module phold_engine #(
    parameter int unsigned NUM_LP    = 4,
    parameter int unsigned TIME_W    = 14,
    parameter int unsigned MIN_DELAY = 1,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int unsigned LP_W     = $clog2(NUM_LP)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   start,
    input  logic [TIME_W-1:0]      end_time,
    output logic                   q_enq,
    output logic [TIME_W+LP_W-1:0] q_enq_data,
    input  logic                   q_full,
    output logic                   q_deq,
    input  logic [TIME_W+LP_W-1:0] q_deq_data,
    input  logic                   q_empty,
    output logic [TIME_W-1:0]      gvt,
    output logic [31:0]            evt_count,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned SUM_W = TIME_W + 8;
    localparam logic [LP_W-1:0] LAST_LP = LP_W'(NUM_LP - 1);

    typedef enum logic [2:0] {IDLE, INIT, PROC, GEN, DONE} state_t;

    state_t            state, state_nx;
    logic [TIME_W-1:0] end_q;
    logic [TIME_W-1:0] held_t;
    logic [LP_W-1:0]   idx;
    logic [15:0]       lfsr;

    logic [TIME_W-1:0] head_t;
    logic              past_end;
    logic [SUM_W-1:0]  sum;
    logic [TIME_W-1:0] new_t;
    logic [LP_W-1:0]   dest;
    logic              fb;

    assign head_t   = q_deq_data[TIME_W+LP_W-1 -: TIME_W];
    assign past_end = head_t > end_q;

    // Wide sum so any carry past TIME_W bits is visible for saturation.
    assign sum   = SUM_W'(held_t) + SUM_W'(MIN_DELAY) + SUM_W'(lfsr[6:0]);
    assign new_t = (|sum[SUM_W-1:TIME_W]) ? '1 : sum[TIME_W-1:0];
    assign dest  = lfsr[15 -: LP_W];
    assign fb    = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    assign busy = state inside {INIT, PROC, GEN};
    assign done = (state == DONE);

    always_comb begin
        state_nx   = state;
        q_enq      = 1'b0;
        q_deq      = 1'b0;
        q_enq_data = '0;
        case (state)
            IDLE: if (start) state_nx = INIT;
            INIT: begin
                q_enq_data = {{TIME_W{1'b0}}, idx};
                if (!q_full) begin
                    q_enq = 1'b1;
                    if (idx == LAST_LP) state_nx = PROC;
                end
            end
            PROC: begin
                if (!q_empty) begin
                    if (past_end) begin
                        state_nx = DONE;
                    end else begin
                        q_deq    = 1'b1;
                        state_nx = GEN;
                    end
                end
            end
            GEN: begin
                q_enq_data = {new_t, dest};
                if (!q_full) begin
                    q_enq    = 1'b1;
                    state_nx = PROC;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Queue handshakes are suppressed on the reset edge so an aborted run never pushes or pops.
        if (reset) begin
            q_enq = 1'b0;
            q_deq = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            gvt       <= '0;
            evt_count <= '0;
            lfsr      <= SEED;
            idx       <= '0;
            end_q     <= '0;
            held_t    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        end_q     <= end_time;
                        evt_count <= '0;
                        idx       <= '0;
                        lfsr      <= SEED;
                    end
                end
                INIT: if (!q_full && idx != LAST_LP) idx <= idx + 1'b1;
                PROC: begin
                    if (!q_empty) begin
                        gvt <= head_t;
                        if (!past_end) held_t <= head_t;
                    end
                end
                GEN: begin
                    if (!q_full) begin
                        evt_count <= evt_count + 32'd1;
                        lfsr      <= {lfsr[14:0], fb};
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PHOLD_TRACE_EN
    always_ff @(posedge CLK) begin
        if (!reset && state == GEN && !q_full)
            $display("%0t phold gen: held=%0d new=%0d dest=%0d", $time, held_t, new_t, dest);
    end
`else
    // No trace output in the default build.
`endif

endmodule

// File: tb/tb_phold_engine.sv
// Scoreboard bench for phold_engine: an ideal min-time queue model feeds the DUT and predicts every push.
module tb_phold_engine;

    localparam int unsigned NUM_LP    = 4;
    localparam int unsigned TIME_W    = 14;
    localparam int unsigned LP_W      = 2;
    localparam int unsigned DW        = TIME_W + LP_W;
    localparam int unsigned MIN_DELAY = 1;
    localparam logic [15:0] SEED      = 16'hACE1;
    localparam logic [9:0]  SAT_HEAD  = {8'd250, 2'd3};

    logic              CLK = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [TIME_W-1:0] end_time = '0;
    logic              q_enq, q_deq, q_full, q_empty, busy, done;
    logic [DW-1:0]     q_enq_data, q_deq_data;
    logic [TIME_W-1:0] gvt;
    logic [31:0]       evt_count;

    logic       s_start = 1'b0;
    logic       s_q_enq, s_q_deq, s_busy, s_done;
    logic [9:0] s_enq_data;
    logic [7:0] s_gvt;
    logic [31:0] s_cnt;

    always #5 CLK = ~CLK;

    phold_engine #(.NUM_LP(NUM_LP), .TIME_W(TIME_W), .MIN_DELAY(MIN_DELAY), .SEED(SEED)) dut (
        .CLK(CLK), .reset(reset), .start(start), .end_time(end_time),
        .q_enq(q_enq), .q_enq_data(q_enq_data), .q_full(q_full),
        .q_deq(q_deq), .q_deq_data(q_deq_data), .q_empty(q_empty),
        .gvt(gvt), .evt_count(evt_count), .busy(busy), .done(done)
    );

    phold_engine #(.NUM_LP(4), .TIME_W(8), .MIN_DELAY(1), .SEED(16'h0014)) u_sat (
        .CLK(CLK), .reset(reset), .start(s_start), .end_time(8'd255),
        .q_enq(s_q_enq), .q_enq_data(s_enq_data), .q_full(1'b0),
        .q_deq(s_q_deq), .q_deq_data(SAT_HEAD), .q_empty(1'b0),
        .gvt(s_gvt), .evt_count(s_cnt), .busy(s_busy), .done(s_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model
    logic              full_force = 1'b0;
    logic              stall_empty = 1'b0;
    logic              clr_pq = 1'b0;
    logic [DW-1:0]     pq[$];
    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     head_r = '0;
    logic              pq_empty_r = 1'b1;
    int                head_i = -1;
    logic [15:0]       lfsr_m = SEED;
    logic [31:0]       cnt_m = '0;
    logic [TIME_W-1:0] end_m = '0;
    logic              m_enq = 1'b0, m_deq = 1'b0;
    logic [DW-1:0]     m_enq_data = '0;

    assign q_full     = full_force;
    assign q_empty    = pq_empty_r | stall_empty;
    assign q_deq_data = head_r;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [DW-1:0] gen_evt(input logic [TIME_W-1:0] t, input logic [15:0] l);
        int unsigned s;
        s = int'(t) + MIN_DELAY + int'(l[6:0]);
        if (s > (1 << TIME_W) - 1) s = (1 << TIME_W) - 1;
        return {s[TIME_W-1:0], l[15 -: LP_W]};
    endfunction

    // Queue update after each edge, using the handshakes sampled on the preceding falling edge.
    always begin
        @(posedge CLK);
        #1;
        if (m_enq) pq.push_back(m_enq_data);
        if (m_deq && head_i >= 0) pq.delete(head_i);
        if (clr_pq) begin
            pq.delete();
            clr_pq = 1'b0;
        end
        head_i = -1;
        foreach (pq[k])
            if (head_i < 0 || pq[k][DW-1:LP_W] < pq[head_i][DW-1:LP_W]) head_i = k;
        head_r     = (head_i >= 0) ? pq[head_i] : '0;
        pq_empty_r = (head_i < 0);
    end

    always @(negedge CLK) begin
        m_enq      = q_enq;
        m_deq      = q_deq;
        m_enq_data = q_enq_data;
        if (q_enq || q_deq) chk("excl", q_enq & q_deq, 0);
        if (q_enq) begin
            if (exp_q.size() == 0) chk("enq_pending", 0, 1);
            else chk("enq_data", q_enq_data, exp_q.pop_front());
        end
        if (q_deq) begin
            chk("deq_nonempty", q_empty, 0);
            chk("deq_horizon", head_r[DW-1:LP_W] <= end_m, 1);
            exp_q.push_back(gen_evt(head_r[DW-1:LP_W], lfsr_m));
            lfsr_m = lfsr_step(lfsr_m);
            cnt_m++;
        end
        if (done) begin
            chk("done_gvt", gvt, head_r[DW-1:LP_W]);
            chk("done_cnt", evt_count, cnt_m);
            chk("done_horizon", head_r[DW-1:LP_W] > end_m, 1);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_start(input logic [TIME_W-1:0] et);
        end_time = et;
        start    = 1'b1;
        end_m    = et;
        lfsr_m   = SEED;
        cnt_m    = '0;
        for (int i = 0; i < NUM_LP; i++) exp_q.push_back(DW'(i));
        step();
        start = 1'b0;
    endtask

    task automatic drain();
        clr_pq = 1'b1;
        repeat (3) step();
        chk("sb_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_done(input bit rand_bp, input bit start_in_done);
        bit got = 1'b0;
        logic [TIME_W-1:0] gv;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
            if (rand_bp) full_force = ($urandom_range(0, 3) == 0);
        end
        full_force = 1'b0;
        chk("done_seen", got, 1);
        gv = gvt;
        if (start_in_done) begin
            start    = 1'b1;
            end_time = '0;
        end
        step();
        start = 1'b0;
        @(negedge CLK);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        repeat (3) @(negedge CLK);
        chk("hold_cnt", evt_count, cnt_m);
        chk("hold_gvt", gvt, gv);
        step();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_gvt"}, gvt, 0);
        chk({tag, "_cnt"}, evt_count, 0);
        chk({tag, "_enq"}, q_enq, 0);
        chk({tag, "_deq"}, q_deq, 0);
        chk({tag, "_data"}, q_enq_data, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (n_checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (3) step();
        reset = 1'b0;
        @(negedge CLK);
        check_idle("rst0");
        step();

        // Saturating time arithmetic on the 8-bit instance
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (s_q_deq) begin
                seen = 1'b1;
                break;
            end
        end
        chk("sat_deq_seen", seen, 1);
        @(negedge CLK);
        chk("sat_enq", s_q_enq, 1);
        chk("sat_time", s_enq_data[9:2], 8'd255);
        chk("sat_dest", s_enq_data[1:0], 0);
        chk("sat_gvt", s_gvt, 8'd250);
        step();

        // Seeding pushes back to back, then a long run with random backpressure
        run_start(14'd300);
        for (int i = 0; i < NUM_LP; i++) begin
            @(negedge CLK);
            chk("init_enq", q_enq, 1);
        end
        @(negedge CLK);
        chk("init_proc_enq", q_enq, 0);
        chk("init_proc_deq", q_deq, 1);
        chk("init_proc_busy", busy, 1);
        wait_done(1'b1, 1'b0);
        drain();

        // Stall while seeding index 2, then a start in DONE is ignored
        run_start(14'd200);
        step();
        step();
        full_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("bp_hold", q_enq, 0);
            step();
        end
        full_force = 1'b0;
        wait_done(1'b0, 1'b1);
        drain();

        // Horizon at zero: only the seeded events are processed
        run_start(14'd0);
        wait_done(1'b0, 1'b0);
        chk("hz_cnt", evt_count, 4);
        chk("hz_gvt_min", gvt >= 1, 1);
        drain();

        // Start pulsed while stalled in PROC must be ignored
        run_start(14'd500);
        for (int c = 0; c < 200 && cnt_m < 3; c++) step();
        stall_empty = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("stall_deq", q_deq, 0);
            step();
            if (c == 2) begin
                start    = 1'b1;
                end_time = '0;
            end
            if (c == 3) start = 1'b0;
        end
        chk("ign_busy", busy, 1);
        chk("ign_cnt", evt_count, cnt_m);
        stall_empty = 1'b0;
        wait_done(1'b0, 1'b0);
        drain();

        // Reset held two cycles while stuck in GEN
        run_start(14'd1000);
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (q_deq) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_deq_seen", seen, 1);
        step();
        full_force = 1'b1;
        reset      = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        chk("rst_gen_enq", q_enq, 0);
        chk("rst_gen_deq", q_deq, 0);
        step();
        @(negedge CLK);
        check_idle("rst1");
        step();
        reset      = 1'b0;
        full_force = 1'b0;
        @(negedge CLK);
        check_idle("rst2");
        step();
        drain();

        // Fresh run after reset must restart the LFSR from SEED
        run_start(14'd150);
        wait_done(1'b1, 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
